// File: rtl/acc_dummy_pipe_if.sv
// Stream interface between the fifo controller and the dummy accelerator.
// Carries the consumer stream (controller -> accelerator) and the producer
// stream (accelerator -> controller).
//   master : controller/environment side (drives cons_*, prod_ready)
//   slave  : accelerator side (drives cons_ready, prod_valid, prod_data)
interface acc_dummy_pipe_if #(
  parameter int DATA_W = 64
);
  logic              cons_valid;
  logic              cons_ready;
  logic [DATA_W-1:0] cons_data;
  logic              prod_valid;
  logic              prod_ready;
  logic [DATA_W-1:0] prod_data;

  modport master (
    output cons_valid, cons_data, prod_ready,
    input  cons_ready, prod_valid, prod_data
  );

  modport slave (
    input  cons_valid, cons_data, prod_ready,
    output cons_ready, prod_valid, prod_data
  );
endinterface

// File: rtl/acc_dummy_pipe.sv
// acc_dummy_pipe: pipelined dummy accelerator.
// Each job consumes ser_ratio beats, waits cfg_wait cycles, then emits
// deser_ratio beats whose value is derived from the job's input beats.
// Ingest of later jobs overlaps with wait/egress of earlier jobs via a
// JOB_DEPTH-entry job queue.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_ser_ratio     input beats per job (0 treated as 1)
//   cfg_deser_ratio   output beats per job (0 treated as 1)
//   cfg_wait          idle cycles between ingest completion and first output
//   cfg_mode          0=last beat, 1=sum, 2=xor, 3=sum+beat index
//   bus (slave)       cons_valid/ready/data in, prod_valid/ready/data out
//   jobs_in_flight    queued jobs, including the one in egress
//   job_done          pulse on the final output handshake of a job
module acc_dummy_pipe #(
  parameter int DATA_W    = 64,
  parameter int JOB_DEPTH = 4,
  parameter int CNT_W     = 16,
  parameter int WAIT_W    = 14
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CNT_W-1:0]               cfg_ser_ratio,
  input  logic [CNT_W-1:0]               cfg_deser_ratio,
  input  logic [WAIT_W-1:0]              cfg_wait,
  input  logic [1:0]                     cfg_mode,
  acc_dummy_pipe_if.slave                bus,
  output logic [$clog2(JOB_DEPTH+1)-1:0] jobs_in_flight,
  output logic                           job_done
);

  localparam int PTR_W = $clog2(JOB_DEPTH);
  localparam int OCC_W = $clog2(JOB_DEPTH+1);

  localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [OCC_W-1:0]  OCC_ZERO  = OCC_W'(0);
  localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0]  OCC_DEPTH = OCC_W'(JOB_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);
  localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_WAIT = 2'd1,
    E_OUT  = 2'd2
  } egr_state_t;

  // A ratio of zero behaves as a ratio of one.
  function automatic logic [CNT_W-1:0] nz_ratio(input logic [CNT_W-1:0] r);
    if (r == CNT_ZERO) begin
      nz_ratio = CNT_ONE;
    end else begin
      nz_ratio = r;
    end
  endfunction

  // ---------------- ingest state ----------------
  logic              in_active_r;
  logic [CNT_W-1:0]  in_cnt_r;
  logic [CNT_W-1:0]  in_ser_r;
  logic [CNT_W-1:0]  in_deser_r;
  logic [WAIT_W-1:0] in_wait_r;
  logic [1:0]        in_mode_r;
  logic [DATA_W-1:0] acc_sum_r;
  logic [DATA_W-1:0] acc_xor_r;
  logic              cons_ready_r;

  logic              cons_hs_s;
  logic              push_s;
  logic [CNT_W-1:0]  job_ser_s;
  logic [CNT_W-1:0]  job_deser_s;
  logic [WAIT_W-1:0] job_wait_s;
  logic [1:0]        job_mode_s;
  logic [CNT_W-1:0]  beat_num_s;
  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] xor_s;
  logic [DATA_W-1:0] result_s;

  // ---------------- job queue ----------------
  logic [DATA_W-1:0] q_result_r [JOB_DEPTH];
  logic [CNT_W-1:0]  q_deser_r  [JOB_DEPTH];
  logic [WAIT_W-1:0] q_wait_r   [JOB_DEPTH];
  logic [1:0]        q_mode_r   [JOB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  count_r;
  logic [OCC_W-1:0]  count_next_s;

  logic [DATA_W-1:0] head_result_s;
  logic [CNT_W-1:0]  head_deser_s;
  logic [WAIT_W-1:0] head_wait_s;
  logic [1:0]        head_mode_s;

  // ---------------- egress state ----------------
  egr_state_t        state_r;
  egr_state_t        state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0]  beat_idx_r;
  logic [DATA_W-1:0] prod_data_r;
  logic              pop_s;
  logic              last_beat_s;

  // Ingest datapath: the first beat of a job takes its config straight from
  // cfg_*, later beats use the copy latched on that first beat.
  always_comb begin
    cons_hs_s   = bus.cons_valid && cons_ready_r;
    job_ser_s   = in_active_r ? in_ser_r   : nz_ratio(cfg_ser_ratio);
    job_deser_s = in_active_r ? in_deser_r : nz_ratio(cfg_deser_ratio);
    job_wait_s  = in_active_r ? in_wait_r  : cfg_wait;
    job_mode_s  = in_active_r ? in_mode_r  : cfg_mode;
    beat_num_s  = in_active_r ? (in_cnt_r + CNT_ONE) : CNT_ONE;
    sum_s       = (in_active_r ? acc_sum_r : DATA_ZERO) + bus.cons_data;
    xor_s       = (in_active_r ? acc_xor_r : DATA_ZERO) ^ bus.cons_data;
    push_s      = cons_hs_s && (beat_num_s == job_ser_s);
    case (job_mode_s)
      2'd0:    result_s = bus.cons_data;
      2'd1:    result_s = sum_s;
      2'd2:    result_s = xor_s;
      2'd3:    result_s = sum_s;
      default: result_s = sum_s;
    endcase
  end

  // Ingest accumulators and per-job config latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_active_r <= 1'b0;
      in_cnt_r    <= CNT_ZERO;
      in_ser_r    <= CNT_ONE;
      in_deser_r  <= CNT_ONE;
      in_wait_r   <= WAIT_ZERO;
      in_mode_r   <= 2'd0;
      acc_sum_r   <= DATA_ZERO;
      acc_xor_r   <= DATA_ZERO;
    end else if (cons_hs_s) begin
      if (push_s) begin
        in_active_r <= 1'b0;
        in_cnt_r    <= CNT_ZERO;
        acc_sum_r   <= DATA_ZERO;
        acc_xor_r   <= DATA_ZERO;
      end else begin
        in_active_r <= 1'b1;
        in_cnt_r    <= beat_num_s;
        in_ser_r    <= job_ser_s;
        in_deser_r  <= job_deser_s;
        in_wait_r   <= job_wait_s;
        in_mode_r   <= job_mode_s;
        acc_sum_r   <= sum_s;
        acc_xor_r   <= xor_s;
      end
    end
  end

  // Queue head view and next occupancy.
  always_comb begin
    head_result_s = q_result_r[rd_ptr_r];
    head_deser_s  = q_deser_r[rd_ptr_r];
    head_wait_s   = q_wait_r[rd_ptr_r];
    head_mode_s   = q_mode_r[rd_ptr_r];
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + OCC_ONE;
      2'b01:   count_next_s = count_r - OCC_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Job queue storage, pointers and occupancy.  cons_ready is registered
  // from the next occupancy so it never depends combinationally on
  // cons_valid or prod_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < JOB_DEPTH; i++) begin
        q_result_r[i] <= DATA_ZERO;
        q_deser_r[i]  <= CNT_ONE;
        q_wait_r[i]   <= WAIT_ZERO;
        q_mode_r[i]   <= 2'd0;
      end
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= OCC_ZERO;
      cons_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        q_result_r[wr_ptr_r] <= result_s;
        q_deser_r[wr_ptr_r]  <= job_deser_s;
        q_wait_r[wr_ptr_r]   <= job_wait_s;
        q_mode_r[wr_ptr_r]   <= job_mode_s;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r      <= count_next_s;
      cons_ready_r <= (count_next_s < OCC_DEPTH);
    end
  end

  // Egress next-state logic.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    last_beat_s  = (beat_idx_r == (head_deser_s - CNT_ONE));
    case (state_r)
      E_IDLE: begin
        if (count_r != OCC_ZERO) begin
          if (head_wait_s != WAIT_ZERO) begin
            state_next_s = E_WAIT;
          end else begin
            state_next_s = E_OUT;
          end
        end else begin
          state_next_s = E_IDLE;
        end
      end
      E_WAIT: begin
        if ((wait_cnt_r + WAIT_ONE) == head_wait_s) begin
          state_next_s = E_OUT;
        end else begin
          state_next_s = E_WAIT;
        end
      end
      E_OUT: begin
        if (bus.prod_ready && last_beat_s) begin
          pop_s        = 1'b1;
          state_next_s = E_IDLE;
        end else begin
          state_next_s = E_OUT;
        end
      end
      default: begin
        state_next_s = E_IDLE;
      end
    endcase
  end

  // Egress state register, wait counter, beat index and output data.
  // prod_data is loaded with the result on entry to E_OUT; in mode 3 it
  // steps by one per handshake, which equals result + beat index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= E_IDLE;
      wait_cnt_r  <= WAIT_ZERO;
      beat_idx_r  <= CNT_ZERO;
      prod_data_r <= DATA_ZERO;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        E_IDLE: begin
          wait_cnt_r <= WAIT_ZERO;
          beat_idx_r <= CNT_ZERO;
          if (state_next_s == E_OUT) begin
            prod_data_r <= head_result_s;
          end
        end
        E_WAIT: begin
          if (state_next_s == E_OUT) begin
            prod_data_r <= head_result_s;
            wait_cnt_r  <= WAIT_ZERO;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        E_OUT: begin
          if (bus.prod_ready) begin
            if (last_beat_s) begin
              beat_idx_r  <= CNT_ZERO;
              prod_data_r <= DATA_ZERO;
            end else begin
              beat_idx_r <= beat_idx_r + CNT_ONE;
              if (head_mode_s == 2'd3) begin
                prod_data_r <= prod_data_r + DATA_ONE;
              end
            end
          end
        end
        default: begin
          wait_cnt_r  <= WAIT_ZERO;
          beat_idx_r  <= CNT_ZERO;
          prod_data_r <= DATA_ZERO;
        end
      endcase
    end
  end

  assign bus.cons_ready = cons_ready_r;
  assign bus.prod_valid = (state_r == E_OUT);
  assign bus.prod_data  = prod_data_r;
  assign jobs_in_flight = count_r;
  // The pop happens exactly on the final output handshake of a job.
  assign job_done       = pop_s;

endmodule

// File: doc/acc_dummy_pipe.md
Name: acc_dummy_pipe

Overview:
- Parametrised next-generation dummy accelerator for the cohort fifo_controller acc_unit slot.
- Consumes N input beats per job, waits a programmable latency, then produces M output beats, with a configurable result function.
- Unlike the single-job dummy, ingest of later jobs overlaps with wait and egress of earlier jobs through an internal job queue.
- Used to model pipelined accelerators and to stress the fifo controller's back-pressure paths.

Parameters:
- DATA_W, 64: width of consumer and producer data.
- JOB_DEPTH, 4: maximum completed-ingest jobs held awaiting or in egress (power of 2, >=2).
- CNT_W, 16: width of the serialization and deserialization ratio fields.
- WAIT_W, 14: width of the wait-cycle field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_ser_ratio  in  CNT_W  input beats per job.
- cfg_deser_ratio  in  CNT_W  output beats per job.
- cfg_wait  in  WAIT_W  idle cycles between job ingest completion and first output.
- cfg_mode  in  2  result function: 0=last beat, 1=sum, 2=xor, 3=sum+beat index.
- cons_valid  in  1  input beat valid.
- cons_ready  out  1  input beat accept.
- cons_data  in  DATA_W  input beat.
- prod_valid  out  1  output beat valid.
- prod_ready  in  1  downstream accept.
- prod_data  out  DATA_W  output beat.
- jobs_in_flight  out  $clog2(JOB_DEPTH+1)  queue occupancy.
- job_done  out  1  one-cycle pulse on the final output handshake of a job.

Behaviour:
- Reset: async on rst_n low. All state cleared. cons_ready=0 during reset, 1 from the first cycle after deassert. prod_valid=0, prod_data=0, jobs_in_flight=0, job_done=0.
- Config latch: cfg_* is sampled into the ingest job on that job's first accepted beat. Changes mid-job do not affect the job. A ratio of 0 is treated as 1.
- Ingest:
  - cons_ready = (registered occupancy < JOB_DEPTH).
  - There is no combinational path from prod_ready or cons_valid to cons_ready.
  - Each handshake updates accumulators: last, sum (mod 2^DATA_W), xor.
  - On the handshake where the beat count reaches ser_ratio, the entry {result, deser_ratio, wait, mode} is pushed. The entry is visible at the next edge, and ingest restarts for a new job.
- Queue: FIFO of JOB_DEPTH entries with pointer wrap-around. jobs_in_flight counts entries, including the one in egress.
  - Push and pop in the same cycle leave the count unchanged.
  - A slot freed by a pop makes cons_ready rise on the following cycle.
- Egress FSM, states E_IDLE, E_WAIT, E_OUT:
  - E_IDLE: if the queue is non-empty, go to E_WAIT (wait>0, counter=0) or E_OUT (wait=0).
  - E_WAIT: counter increments each cycle. When counter+1==wait, go to E_OUT.
  - E_OUT: prod_valid=1. On each handshake, the beat index increments.
  - On the handshake of beat deser_ratio-1: pop the entry, pulse job_done, return to E_IDLE.
  - Back-to-back jobs therefore have one idle cycle between them.
- Latency: last input handshake at cycle T gives first prod_valid at T+2+wait.
- prod_data:
  - Modes 0, 1, 2: the entry's result, constant over all beats.
  - Mode 3: result + beat index, mod 2^DATA_W.
  - prod_data and prod_valid stay stable while prod_valid && !prod_ready.
- Simultaneous events: ingest push and egress pop in the same cycle are both honoured. A push into an empty queue while egress is E_IDLE is seen next cycle.
- Reset mid-operation: in-flight jobs are discarded, with no partial output after deassert.

Test Plan:
- Single job: ser=4, deser=2, wait=3, mode 1, inputs 1,2,3,4 with prod_ready=1. Expect two beats of 10. First prod_valid 5 cycles after the last input handshake. job_done pulses with the 2nd beat.
- Mode 3 with back-pressure: ser=2, deser=4, wait=0, inputs 0x10,0x20, prod_ready toggling 1/0. Expect 0x30,0x31,0x32,0x33. prod_data stable while stalled. No duplicated or dropped beats.
- Queue full: JOB_DEPTH=4, ser=1, wait=10, prod_ready=0, continuous cons_valid. Expect exactly 4 beats accepted. cons_ready=0 with jobs_in_flight=4. cons_ready returns one cycle after the first pop.
- Overlap and config latch: start job A with ser=3 and mode 2, then change cfg_mode to 0 mid-job. A outputs the xor of its beats. Job B, ingested during A's wait, outputs its last beat. Order A then B.
- Zero ratios: ser=0, deser=0, wait=0, input 0xAB, mode 0. Expect exactly one output beat 0xAB and a job_done pulse.
- Async reset mid-egress: assert rst_n low during E_OUT with 2 jobs queued. Outputs clear immediately. After release, no prod_valid until a new job completes.
